// File: rtl/cic_rate_ctrl_if.sv
// rtl/cic_rate_ctrl_if.sv - config/strobe bundle between the CIC rate controller and its host/datapath
interface cic_rate_ctrl_if;
    logic       cfg_wr;
    logic [2:0] cfg_os_sel;
    logic       in_valid;
    logic [2:0] os_sel_out;
    logic       dec_tick;
    logic       out_valid;
    logic       cfg_busy;
    logic       cfg_err;
    logic [1:0] state_o;

    modport master (
        output cfg_wr, cfg_os_sel, in_valid,
        input  os_sel_out, dec_tick, out_valid, cfg_busy, cfg_err, state_o
    );

    modport slave (
        input  cfg_wr, cfg_os_sel, in_valid,
        output os_sel_out, dec_tick, out_valid, cfg_busy, cfg_err, state_o
    );
endinterface

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - CIC decimator rate controller: flush/warm-up sequencing, decimation tick, out_valid
// Optional macro CIC_WARMUP_EN enables the WARM state; undefined, FLUSH goes straight to RUN.
module cic_rate_ctrl #(
    parameter int unsigned NSTAGE    = 4,
    parameter int unsigned FLUSH_CYC = 4,
    parameter int unsigned CNTW      = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    cic_rate_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_WARM  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam int unsigned   FW         = $clog2(FLUSH_CYC + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [FW-1:0] FC_ONE     = FW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW:0]   ONE_W    = (CNTW + 1)'(1);

    generate
        if (FLUSH_CYC < 1 || NSTAGE < 1 || CNTW < 6) begin : g_bad_param
            $error("cic_rate_ctrl: illegal parameter set");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [2:0]      cur_sel_q, cur_sel_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            dec_tick_q, dec_tick_d;
    logic            out_valid_q, out_valid_d;
    logic            cfg_err_q, cfg_err_d;
    logic            cfg_busy_q, cfg_busy_d;
    logic [2:0]      os_sel_q, os_sel_d;
    logic [CNTW:0]   r_wide;
    logic [CNTW-1:0] r_m1;
    logic            accept;

`ifdef CIC_WARMUP_EN
    localparam int unsigned   WW        = $clog2(NSTAGE + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(NSTAGE - 1);
    localparam logic [WW-1:0] WC_ONE    = WW'(1);
    logic [WW-1:0] warm_cnt_q, warm_cnt_d;
`endif

    // R-1 computed one bit wider so os_sel=6 with CNTW=6 wraps cleanly to all-ones.
    assign r_wide = ONE_W << cur_sel_q;
    assign r_m1   = r_wide[CNTW-1:0] - CNT_ONE;
    assign accept = bus.cfg_wr && (bus.cfg_os_sel != 3'd7);

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;
        dec_tick_d  = 1'b0;
        // A tick already on the wire still yields its out_valid, even across a write.
        out_valid_d = dec_tick_q && (state_q == S_RUN);
        cfg_err_d   = bus.cfg_wr && (bus.cfg_os_sel == 3'd7);
`ifdef CIC_WARMUP_EN
        warm_cnt_d  = warm_cnt_q;
`endif
        if (accept) begin
            cur_sel_d   = bus.cfg_os_sel;
            cnt_d       = '0;
            flush_cnt_d = '0;
            state_d     = (bus.cfg_os_sel == 3'd0) ? S_IDLE : S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
`ifdef CIC_WARMUP_EN
                        state_d    = S_WARM;
                        warm_cnt_d = '0;
`else
                        state_d    = S_RUN;
`endif
                    end else begin
                        flush_cnt_d = flush_cnt_q + FC_ONE;
                    end
                end
                default: begin
                    if (bus.in_valid) begin
                        if (cnt_q == r_m1) begin
                            cnt_d      = '0;
                            dec_tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
`ifdef CIC_WARMUP_EN
                    if ((state_q == S_WARM) && dec_tick_q) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d = S_RUN;
                        end else begin
                            warm_cnt_d = warm_cnt_q + WC_ONE;
                        end
                    end
`endif
                end
            endcase
        end
        os_sel_d   = ((state_d == S_WARM) || (state_d == S_RUN)) ? cur_sel_d : 3'd0;
        cfg_busy_d = (state_d == S_FLUSH) || (state_d == S_WARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_sel_q   <= 3'd0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            dec_tick_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_busy_q  <= 1'b0;
            os_sel_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            dec_tick_q  <= dec_tick_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            cfg_busy_q  <= cfg_busy_d;
            os_sel_q    <= os_sel_d;
        end
    end

`ifdef CIC_WARMUP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt_q <= '0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
        end
    end
`endif

    assign bus.os_sel_out = os_sel_q;
    assign bus.dec_tick   = dec_tick_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.cfg_busy   = cfg_busy_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - scoreboard bench for cic_rate_ctrl against a behavioural rate model
module tb_cic_rate_ctrl;
    localparam int NSTAGE    = 4;
    localparam int FLUSH_CYC = 4;
`ifdef CIC_WARMUP_EN
    localparam bit WARMUP = 1'b1;
`else
    localparam bit WARMUP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] os;
        logic       tick;
        logic       ov;
        logic       busy;
        logic       err;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Model: mode 0 idle, 1 flush, 2 warm, 3 run; counts kept as plain integers.
    int   m_mode = 0;
    int   m_sel = 0;
    int   m_age = 0;
    int   m_n = 0;
    int   m_wt = 0;
    bit   e_tick = 1'b0;

    cic_rate_ctrl_if bus();

    cic_rate_ctrl #(.NSTAGE(NSTAGE), .FLUSH_CYC(FLUSH_CYC), .CNTW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t pack_exp(input int mode, input bit tick, input bit ov, input bit err);
        exp_t e;
        e.os   = ((mode == 2) || (mode == 3)) ? 3'(m_sel) : 3'd0;
        e.tick = tick;
        e.ov   = ov;
        e.busy = (mode == 1) || (mode == 2);
        e.err  = err;
        e.st   = 2'(mode);
        return e;
    endfunction

    task automatic model_step(input bit w, input int v, input bit iv);
        int  nm;
        bit  tick;
        bit  ov;
        bit  err;
        tick = 1'b0;
        ov   = e_tick && (m_mode == 3);
        err  = w && (v == 7);
        nm   = m_mode;
        if (w && v != 7) begin
            m_sel = v;
            m_n   = 0;
            m_age = 0;
            m_wt  = 0;
            nm    = (v == 0) ? 0 : 1;
        end else if (m_mode == 1) begin
            m_age++;
            if (m_age == FLUSH_CYC) nm = WARMUP ? 2 : 3;
        end else if (m_mode >= 2) begin
            if (iv) begin
                m_n++;
                if ((m_n % (1 << m_sel)) == 0) tick = 1'b1;
            end
            if (m_mode == 2 && e_tick) begin
                m_wt++;
                if (m_wt == NSTAGE) nm = 3;
            end
        end
        m_mode = nm;
        e_tick = tick;
        exp_q.push_back(pack_exp(nm, tick, ov, err));
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_mode = 0; m_sel = 0; m_age = 0; m_n = 0; m_wt = 0; e_tick = 1'b0;
                exp_q.delete();
                exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 1'b0));
            end else begin
                model_step(bus.cfg_wr, int'(bus.cfg_os_sel), bus.in_valid);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("os_sel_out", int'(bus.os_sel_out), int'(e.os));
            chk("dec_tick",   int'(bus.dec_tick),   int'(e.tick));
            chk("out_valid",  int'(bus.out_valid),  int'(e.ov));
            chk("cfg_busy",   int'(bus.cfg_busy),   int'(e.busy));
            chk("cfg_err",    int'(bus.cfg_err),    int'(e.err));
            chk("state_o",    int'(bus.state_o),    int'(e.st));
        end
    end

    task automatic drive(input bit w, input int v, input bit iv);
        bus.cfg_wr     = w;
        bus.cfg_os_sel = 3'(v);
        bus.in_valid   = iv;
        @(posedge clk);
        #1;
        bus.cfg_wr = 1'b0;
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) drive(1'b0, 0, $urandom_range(0, 99) < pct);
    endtask

    task automatic wait_state(input int target, input int budget, input int pct);
        int k;
        k = 0;
        while (int'(bus.state_o) != target && k < budget) begin
            drive(1'b0, 0, $urandom_range(0, 99) < pct);
            k++;
        end
        chk("wait_state", int'(bus.state_o), target);
    endtask

    initial begin
        bus.cfg_wr = 1'b0;
        bus.cfg_os_sel = 3'd0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_os_sel", int'(bus.os_sel_out), 0);
        chk("reset_state",  int'(bus.state_o), 0);
        reset_n = 1'b1;
        run(5, 100);

        // R=2 with in_valid held high: flush then warm-up then run.
        drive(1'b1, 1, 1'b1);
        run(40, 100);

        // R=64, a sample every third cycle.
        drive(1'b1, 6, 1'b0);
        for (int i = 0; i < 1400; i++) drive(1'b0, 0, (i % 3) == 0);

        // Rejected write of 7 while running at R=8.
        drive(1'b1, 3, 1'b1);
        wait_state(3, 200, 70);
        run(60, 70);
        drive(1'b1, 7, 1'b1);
        run(60, 70);

        // Reconfigure exactly in the cycle a tick would fire at R=16.
        drive(1'b1, 4, 1'b1);
        wait_state(3, 300, 100);
        for (int k = 0; k < 100; k++) begin
            if (m_mode == 3 && ((m_n + 1) % 16) == 0) break;
            drive(1'b0, 0, 1'b1);
        end
        drive(1'b1, 2, 1'b1);
        run(60, 100);

        // Disable during warm-up (run when warm-up is compiled out).
        drive(1'b1, 2, 1'b1);
        wait_state(WARMUP ? 2 : 3, 50, 100);
        run(3, 100);
        drive(1'b1, 0, 1'b1);
        run(40, 100);

        // Asynchronous reset between edges while running.
        drive(1'b1, 5, 1'b1);
        wait_state(3, 400, 100);
        run(20, 100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_os_sel", int'(bus.os_sel_out), 0);
        chk("async_rst_tick",   int'(bus.dec_tick), 0);
        chk("async_rst_ov",     int'(bus.out_valid), 0);
        chk("async_rst_busy",   int'(bus.cfg_busy), 0);
        chk("async_rst_state",  int'(bus.state_o), 0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run(20, 100);
        drive(1'b1, 1, 1'b1);
        run(30, 100);

        // Randomised writes and sample strobes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) drive(1'b1, int'($urandom_range(0, 7)), $urandom_range(0, 99) < 60);
            else drive(1'b0, 0, $urandom_range(0, 99) < 60);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
Rate controller and sequencer for the CIC decimator comb chain. Owns the oversampling select driven to the integrator/comb stages and generates the decimation tick (comb clock enable). It also generates the output-valid strobe. Reconfiguration is glitch-free: the chain is forced into its clear state (os_sel = 0) for a flush window, then warmed up before output samples are declared valid.

Parameters:
NSTAGE, 4, number of comb stages; decimated ticks suppressed after a (re)configuration before out_valid is allowed.
FLUSH_CYC, 4, clk cycles os_sel_out is held at 3'b000 on reconfiguration (minimum 1).
CNTW, 6, width of the input-sample counter; must satisfy 2^CNTW >= 64.

Ports:
clk  input  1  clock.
reset_n  input  1  asynchronous active-low reset.
cfg_wr  input  1  single-cycle write strobe for cfg_os_sel.
cfg_os_sel  input  3  requested ratio select: 0 = disable, 1..6 give R = 2^os_sel, 7 = illegal.
in_valid  input  1  high-rate input sample strobe (one per modulator sample).
os_sel_out  output  3  select driven to integrator/comb datapath.
dec_tick  output  1  one-cycle decimation strobe (comb enable).
out_valid  output  1  one-cycle strobe marking a valid comb data_out.
cfg_busy  output  1  high while in FLUSH or WARM.
cfg_err  output  1  one-cycle pulse when a write of 7 is rejected.
state_o  output  2  current state (IDLE=0, FLUSH=1, WARM=2, RUN=3).

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous assert, active-low.
- On reset: state IDLE; os_sel_out=0, dec_tick=0, out_valid=0, cfg_busy=0, cfg_err=0. Internal cur_sel=0, sample counter=0, flush/warm counters=0.
- Config write (cfg_wr=1) is accepted in every state and takes priority over all other events in that cycle.
  - Value 7: ignored; state and cur_sel unchanged; cfg_err pulses high the next cycle.
  - Value 0: next state IDLE; cur_sel=0.
  - Value 1..6: cur_sel=value; next state FLUSH; flush counter=0; sample counter=0.
  - Any dec_tick that would have fired in the write cycle is suppressed.
- IDLE: os_sel_out=0; sample counter held at 0; no dec_tick.
- FLUSH: os_sel_out=0 (datapath clears its delay/flag registers). After FLUSH_CYC cycles, go to WARM; warm counter=0. in_valid is ignored during FLUSH.
- WARM and RUN:
  - os_sel_out=cur_sel (registered).
  - The sample counter increments on each in_valid. When in_valid arrives with counter = R-1, the counter wraps to 0 and dec_tick is high the next cycle (registered, exactly one cycle wide).
- WARM: each dec_tick increments the warm counter. When the NSTAGE-th tick is issued, go to RUN; out_valid stays low for all WARM ticks.
- RUN: out_valid = dec_tick delayed by one cycle, matching the comb output register latency.
- cfg_busy = (state==FLUSH) or (state==WARM), registered with state.
- A tick issued in the last WARM cycle produces no out_valid. The first out_valid follows the first tick issued in RUN.
- A reconfiguration in RUN while an out_valid is pending (tick in the previous cycle): the pending out_valid still fires. No further ticks until WARM completes again.
- in_valid on consecutive cycles is legal; at R=2, dec_tick may then occur every 2 cycles.
- Arithmetic: counter compare uses R-1 = (1<<cur_sel)-1, zero-extended to CNTW.
- Reset mid-operation returns everything to reset values immediately. No tick or out_valid is emitted during or after reset until a new write occurs.

Optional Feature:
Macro CIC_WARMUP_EN.
- Defined: WARM state is active as above (NSTAGE suppressed ticks).
- Undefined: FLUSH transitions directly to RUN; the warm counter is removed; state_o never reports 2. out_valid may then follow the first tick after flush, including transient comb output.

Test Plan:
1. Reset, then cfg_wr os_sel=1, in_valid held high -> os_sel_out=0 for 4 cycles, then 1. dec_tick pulses every 2 cycles; first 4 ticks without out_valid; 5th tick followed by out_valid one cycle later; cfg_busy falls on entering RUN.
2. RUN at os_sel=6, in_valid every 3rd cycle -> dec_tick period 192 cycles, each followed by out_valid; cycle-exact versus model.
3. Write 7 during RUN at os_sel=3 -> cfg_err one pulse; os_sel_out stays 3; tick cadence undisturbed.
4. Write os_sel=2 in the same cycle a tick would fire in RUN at os_sel=4 -> that tick suppressed; FLUSH 4 cycles; then 4 WARM ticks at R=4 before out_valid resumes.
5. Write 0 during WARM -> state IDLE next cycle; os_sel_out=0; no further dec_tick or out_valid despite in_valid.
6. Assert reset_n low mid-RUN, asynchronously between clk edges -> all outputs 0 immediately; after release, idle until next write. Repeat with CIC_WARMUP_EN undefined -> out_valid after first tick post-flush.
